button_event_gen: RTL and testbench
===================================

Name: button_event_gen

Overview:
- Sits directly downstream of the push-button debouncer; consumes its clean, active-low button level.
- Classifies each press as short or long and presents one event at a time to the bus master control logic over a req/ack handshake.
- Produces the single, well-defined event per press that the master FSM needs to start serial bus transactions.
- Fully synchronous to clk.

Parameters:
- LONG_PRESS_CYCLES, default 50_000_000: consecutive held cycles that make a press long (1 s at 50 MHz); must be >= 2.
- REPEAT_CYCLES, default 10_000_000: auto-repeat period while held long; used only with BTN_AUTO_REPEAT_EN.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- btn_n  in  1  debounced button level; 0 = pressed, 1 = released.
- evt_req  out  1  event pending; held until accepted.
- evt_code  out  2  event type: 01 short, 10 long, 11 repeat, 00 none.
- evt_ack  in  1  consumer accepts the pending event.
- evt_drop  out  1  one-cycle pulse: an event was lost because one was already pending.
- pressed  out  1  registered level, 1 while the FSM is in PRESSED or LONG_HELD.

Behaviour:
- Reset values: evt_req=0, evt_code=00, evt_drop=0, pressed=0; FSM=ARM; hold counter=0.
- Reset is asynchronous assert; all state is clocked on the rising edge of clk after release.
- FSM states: ARM, IDLE, PRESSED, LONG_HELD.
- ARM: stays while btn_n==0, so a button held through reset never creates an event; goes to IDLE on the first edge that samples btn_n==1.
- IDLE: on an edge sampling btn_n==0, go to PRESSED with hold counter=1 and pressed=1 after that edge.
- PRESSED, btn_n==0: counter increments. On the edge where the counter would reach LONG_PRESS_CYCLES:
  - raise a long event (code 10);
  - go to LONG_HELD;
  - evt_req is visible after that same edge, so a hold of exactly LONG_PRESS_CYCLES samples gives long.
- PRESSED, btn_n==1: raise a short event (code 01); go to IDLE; pressed=0 after that edge.
- LONG_HELD: no event on release; on btn_n==1 go to IDLE and set pressed=0.
- Hold counter: width $clog2(LONG_PRESS_CYCLES+1); saturates, never wraps; cleared on entry to IDLE.
- Handshake:
  - evt_req and evt_code stay stable while evt_req==1 and evt_ack==0.
  - Transfer happens on an edge where evt_req==1 and evt_ack==1; evt_req=0 and evt_code=00 after it.
  - evt_ack while evt_req==0 is ignored.
  - Event raised on the same edge as a transfer: the new event is loaded, evt_req stays 1 and evt_code takes the new value. No bubble, no drop.
  - Event raised while pending and not transferring: new event discarded, pending unchanged, evt_drop=1 for exactly one cycle.
- Mid-operation reset: all outputs return to reset values immediately; any pending event is lost; the FSM re-enters ARM.
- No combinational path from any input to any output. All outputs are registered.

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- Defined:
  - LONG_HELD keeps a repeat counter, cleared on entry.
  - Every REPEAT_CYCLES consecutive held cycles it raises a repeat event (code 11); the counter wraps to 0 after each repeat.
  - Repeat events follow the same handshake and drop rules.
  - The repeat counter is cleared on release and on reset.
- Undefined: no repeat counter logic is generated and code 11 is never produced.

Test Plan (LONG_PRESS_CYCLES=8, REPEAT_CYCLES=4):
- Reset with btn_n=1, release rst, hold btn_n=0 for 3 cycles then 1 -> pressed=1 for 3 cycles; evt_req=1 and evt_code=01 after the release edge; ack one cycle -> evt_req=0, code=00 next cycle.
- Hold btn_n=0 for 20 cycles -> evt_req=1, code=10 after the 8th low sample; no event on release; pressed falls after the release edge.
- Hold btn_n=0 through reset release, keep low for 20 cycles, then release -> no event and pressed stays 0; a following 3-cycle press gives code 01.
- Short event left unacked, second short press -> evt_drop one-cycle pulse; evt_code stays 01; ack -> evt_req clears.
- Short press, then a second press whose release edge coincides with evt_ack=1 -> evt_req stays 1 with code 01 (the new event) and evt_drop=0.
- With BTN_AUTO_REPEAT_EN, ack tied to 1, hold 16 cycles -> codes 10 at low sample 8, then 11 at samples 12 and 16. Without the macro, same stimulus -> only 10.

Source files
------------

// File: rtl/button_event_gen.sv
// -----------------------------------------------------------------------------
// button_event_gen
//
// Turns the debounced, active-low push-button level into discrete press
// events (short / long, optionally auto-repeat) and offers them one at a
// time to the bus master over a req/ack handshake.
//
// Optional feature macro: BTN_AUTO_REPEAT_EN
//   When defined, a button held past the long-press threshold produces a
//   repeat event (code 11) every REPEAT_CYCLES held cycles. When undefined,
//   no repeat logic exists and code 11 is never produced.
//
// Parameters
//   LONG_PRESS_CYCLES  consecutive held cycles that make a press long (>= 2)
//   REPEAT_CYCLES      auto-repeat period while held long (repeat build only)
//
// Ports
//   clk       in   system clock
//   rst       in   asynchronous, active-high reset
//   btn_n     in   debounced button level, 0 = pressed
//   evt_req   out  event pending, held until accepted
//   evt_code  out  00 none, 01 short, 10 long, 11 repeat
//   evt_ack   in   consumer accepts the pending event
//   evt_drop  out  one-cycle pulse: an event was lost, one already pending
//   pressed   out  1 while the FSM is in PRESSED or LONG_HELD
//
// Handshake: an event is offered by holding evt_req=1 with a stable
// evt_code. It transfers on any rising edge where evt_req=1 and evt_ack=1;
// evt_ack while evt_req=0 has no effect. A new event raised on the very
// edge of a transfer replaces the outgoing one with no idle gap; a new
// event raised while one is pending and not transferring is discarded and
// reported on evt_drop.
//
// All outputs are registered; no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module button_event_gen #(
    parameter int unsigned LONG_PRESS_CYCLES = 50_000_000,
    parameter int unsigned REPEAT_CYCLES     = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    output logic       evt_req,
    output logic [1:0] evt_code,
    input  logic       evt_ack,
    output logic       evt_drop,
    output logic       pressed
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (LONG_PRESS_CYCLES < 2) begin : g_bad_long
        $error("button_event_gen: LONG_PRESS_CYCLES must be >= 2");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("button_event_gen: REPEAT_CYCLES must be >= 1");
    end

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
    // The long event fires on the edge where the counter would reach
    // HOLD_MAX, i.e. while it still holds HOLD_MAX-1.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    localparam logic [1:0] CODE_NONE   = 2'b00;
    localparam logic [1:0] CODE_SHORT  = 2'b01;
    localparam logic [1:0] CODE_LONG   = 2'b10;
`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [1:0] CODE_REPEAT = 2'b11;

    localparam int unsigned RPT_W = $clog2(REPEAT_CYCLES + 1);

    localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        ST_ARM       = 2'd0,
        ST_IDLE      = 2'd1,
        ST_PRESSED   = 2'd2,
        ST_LONG_HELD = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q;
    state_t              state_d;
    logic [HOLD_W-1:0]   hold_q;
    logic [HOLD_W-1:0]   hold_d;
`ifdef BTN_AUTO_REPEAT_EN
    logic [RPT_W-1:0]    rpt_q;
    logic [RPT_W-1:0]    rpt_d;
`endif

    // Event request from the FSM towards the handshake register.
    logic                raise;
    logic [1:0]          raise_code;

    logic                xfer;
    logic                pressed_d;

    // ------------------------------------------------------------------
    // FSM state register and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ARM;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // FSM next-state and event generation
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        raise      = 1'b0;
        raise_code = CODE_NONE;
`ifdef BTN_AUTO_REPEAT_EN
        rpt_d      = rpt_q;
`endif

        case (state_q)
            // A button held through reset must be released once before it
            // can produce any event.
            ST_ARM: begin
                if (btn_n) begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end
            end

            ST_IDLE: begin
                hold_d = '0;
                if (!btn_n) begin
                    state_d = ST_PRESSED;
                    hold_d  = HOLD_ONE;
                end
            end

            ST_PRESSED: begin
                if (btn_n) begin
                    state_d    = ST_IDLE;
                    hold_d     = '0;
                    raise      = 1'b1;
                    raise_code = CODE_SHORT;
                end else if (hold_q == HOLD_LAST) begin
                    state_d    = ST_LONG_HELD;
                    hold_d     = HOLD_MAX;
                    raise      = 1'b1;
                    raise_code = CODE_LONG;
`ifdef BTN_AUTO_REPEAT_EN
                    rpt_d      = '0;
`endif
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end

            ST_LONG_HELD: begin
                if (btn_n) begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
`ifdef BTN_AUTO_REPEAT_EN
                    rpt_d   = '0;
`endif
                end else begin
                    // Saturate rather than wrap on very long holds.
                    if (hold_q != HOLD_MAX) begin
                        hold_d = hold_q + HOLD_ONE;
                    end
`ifdef BTN_AUTO_REPEAT_EN
                    if (rpt_q == RPT_LAST) begin
                        rpt_d      = '0;
                        raise      = 1'b1;
                        raise_code = CODE_REPEAT;
                    end else begin
                        rpt_d = rpt_q + RPT_ONE;
                    end
`endif
                end
            end

            default: begin
                state_d = ST_ARM;
                hold_d  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output handshake register
    // ------------------------------------------------------------------
    assign xfer      = evt_req & evt_ack;
    assign pressed_d = (state_d == ST_PRESSED) || (state_d == ST_LONG_HELD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_req  <= 1'b0;
            evt_code <= CODE_NONE;
            evt_drop <= 1'b0;
            pressed  <= 1'b0;
        end else begin
            pressed  <= pressed_d;
            evt_drop <= 1'b0;
            if (raise) begin
                // Slot is free, or is being emptied on this very edge.
                if (!evt_req || xfer) begin
                    evt_req  <= 1'b1;
                    evt_code <= raise_code;
                end else begin
                    evt_drop <= 1'b1;
                end
            end else if (xfer) begin
                evt_req  <= 1'b0;
                evt_code <= CODE_NONE;
            end
        end
    end

endmodule

// File: tb/tb_button_event_gen.sv
// -----------------------------------------------------------------------------
// tb_button_event_gen
//
// Directed bench for button_event_gen with LONG_PRESS_CYCLES=8 and
// REPEAT_CYCLES=4. Inputs change 1 ns after each rising edge and outputs are
// sampled at the same point, so every check sees the result of the edge just
// taken. Expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_button_event_gen;

    logic       clk;
    logic       rst;
    logic       btn_n;
    logic       evt_req;
    logic [1:0] evt_code;
    logic       evt_ack;
    logic       evt_drop;
    logic       pressed;

    int checks;
    int errors;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    button_event_gen #(
        .LONG_PRESS_CYCLES (8),
        .REPEAT_CYCLES     (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_n    (btn_n),
        .evt_req  (evt_req),
        .evt_code (evt_code),
        .evt_ack  (evt_ack),
        .evt_drop (evt_drop),
        .pressed  (pressed)
    );

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold the button for n samples, then release it on the next edge.
    task automatic short_press(input int n);
        btn_n = 1'b0;
        tick(n);
        btn_n = 1'b1;
        tick(1);
    endtask

    task automatic ack_once();
        evt_ack = 1'b1;
        tick(1);
        evt_ack = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Checker
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        btn_n   = 1'b1;
        evt_ack = 1'b0;

        // Reset values
        tick(2);
        check("rst_req",     32'(evt_req),  0);
        check("rst_code",    32'(evt_code), 0);
        check("rst_drop",    32'(evt_drop), 0);
        check("rst_pressed", 32'(pressed),  0);
        rst = 1'b0;
        tick(1);                        // ARM -> IDLE

        // Short press of 3 samples
        btn_n = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            check("t1_pressed", 32'(pressed), 1);
            check("t1_req_low", 32'(evt_req), 0);
        end
        btn_n = 1'b1;
        tick(1);
        check("t1_pressed_rel", 32'(pressed),  0);
        check("t1_req",         32'(evt_req),  1);
        check("t1_code",        32'(evt_code), 1);
        ack_once();
        check("t1_req_ack",  32'(evt_req),  0);
        check("t1_code_ack", 32'(evt_code), 0);

        // Long press, held 20 samples, unacked while held
        btn_n = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            if (k == 7) check("t2_req_s7", 32'(evt_req), 0);
            if (k == 8) begin
                check("t2_req_s8",  32'(evt_req),  1);
                check("t2_code_s8", 32'(evt_code), 2);
            end
            if (k == 20) begin
                check("t2_code_s20",    32'(evt_code), 2);
                check("t2_pressed_s20", 32'(pressed),  1);
            end
        end
        btn_n = 1'b1;
        tick(1);
        check("t2_pressed_rel", 32'(pressed),  0);
        check("t2_req_rel",     32'(evt_req),  1);
        check("t2_code_rel",    32'(evt_code), 2);
        ack_once();
        check("t2_req_ack", 32'(evt_req), 0);

        // Boundary: 7 samples is still short
        short_press(7);
        check("t7_req",  32'(evt_req),  1);
        check("t7_code", 32'(evt_code), 1);
        ack_once();
        check("t7_req_ack", 32'(evt_req), 0);

        // Button held through reset release
        rst   = 1'b1;
        btn_n = 1'b0;
        tick(2);
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            if (k == 10 || k == 20) begin
                check("t3_pressed_held", 32'(pressed), 0);
                check("t3_req_held",     32'(evt_req), 0);
            end
        end
        btn_n = 1'b1;
        tick(1);
        check("t3_req_rel",     32'(evt_req), 0);
        check("t3_pressed_rel", 32'(pressed), 0);
        short_press(3);
        check("t3_req_after",  32'(evt_req),  1);
        check("t3_code_after", 32'(evt_code), 1);
        ack_once();
        check("t3_req_ack", 32'(evt_req), 0);

        // Drop: second short press while the first is unacked
        short_press(3);
        check("t4_req_first", 32'(evt_req), 1);
        short_press(2);
        check("t4_drop",  32'(evt_drop), 1);
        check("t4_req",   32'(evt_req),  1);
        check("t4_code",  32'(evt_code), 1);
        tick(1);
        check("t4_drop_pulse", 32'(evt_drop), 0);
        ack_once();
        check("t4_req_ack", 32'(evt_req), 0);

        // Event raised on the transfer edge: short over short
        short_press(3);
        btn_n = 1'b0;
        tick(2);
        btn_n   = 1'b1;
        evt_ack = 1'b1;
        tick(1);
        check("t5_req",  32'(evt_req),  1);
        check("t5_code", 32'(evt_code), 1);
        check("t5_drop", 32'(evt_drop), 0);
        tick(1);
        evt_ack = 1'b0;
        check("t5_req_ack", 32'(evt_req), 0);

        // Event raised on the transfer edge: short replaces pending long
        btn_n = 1'b0;
        tick(8);
        check("t5b_code_long", 32'(evt_code), 2);
        btn_n = 1'b1;
        tick(1);
        btn_n = 1'b0;
        tick(2);
        btn_n   = 1'b1;
        evt_ack = 1'b1;
        tick(1);
        check("t5b_req",  32'(evt_req),  1);
        check("t5b_code", 32'(evt_code), 1);
        check("t5b_drop", 32'(evt_drop), 0);
        tick(1);
        evt_ack = 1'b0;
        check("t5b_req_ack", 32'(evt_req), 0);

        // Ack tied high, 16-sample hold
        evt_ack = 1'b1;
        btn_n   = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            if (k == 8) begin
                check("t6_req_s8",  32'(evt_req),  1);
                check("t6_code_s8", 32'(evt_code), 2);
            end
            if (k == 9) check("t6_req_s9", 32'(evt_req), 0);
            if (k == 12 || k == 16) begin
`ifdef BTN_AUTO_REPEAT_EN
                check("t6_req_rpt",  32'(evt_req),  1);
                check("t6_code_rpt", 32'(evt_code), 3);
`else
                check("t6_req_rpt",  32'(evt_req),  0);
                check("t6_code_rpt", 32'(evt_code), 0);
`endif
            end
            if (k == 13) check("t6_req_s13", 32'(evt_req), 0);
        end
        btn_n = 1'b1;
        tick(1);
        evt_ack = 1'b0;
        check("t6_req_rel",     32'(evt_req), 0);
        check("t6_pressed_rel", 32'(pressed), 0);

        // Asynchronous reset mid-cycle with an event pending and button down
        short_press(3);
        btn_n = 1'b0;
        tick(2);
        check("t8_pre_req",     32'(evt_req), 1);
        check("t8_pre_pressed", 32'(pressed), 1);
        #2;
        rst = 1'b1;
        #1;
        check("t8_req",     32'(evt_req),  0);
        check("t8_code",    32'(evt_code), 0);
        check("t8_pressed", 32'(pressed),  0);
        btn_n = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        short_press(3);
        check("t8_req_after",  32'(evt_req),  1);
        check("t8_code_after", 32'(evt_code), 1);
        ack_once();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
